// File: rtl/aes_pkg.sv
// Shared types and widths for the AES packet scheduler slice.
// State encodings are one-hot so each state is a single flop bit.
package aes_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd1,
        FIRST = 4'd2,
        BODY  = 4'd4,
        DRAIN = 4'd8
    } state_t;

    localparam int BLOCK_W  = 128;
    localparam int BYPASS_W = 289;
    localparam int LEN_MSB  = 48;
    localparam int LEN_LSB  = 33;

    function automatic logic [LEN_MSB-LEN_LSB:0] bypass_len(
        input logic [BYPASS_W-1:0] b
    );
        return b[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr.
// Produces both a one-hot grant and its encoded index.
module aes_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/aes_pkt_sched.sv
// Packet-boundary round-robin scheduler in front of one aes_api GCM engine.
// Limits packets in flight and truncates over-length packets.
module aes_pkt_sched
    import aes_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int MAX_WORDS    = 94
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*128-1:0]        i_req_text,
    input  logic [NUM_REQ*289-1:0]        i_req_bypass,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_pkt_done,
    output logic                          o_new,
    output logic                          o_last,
    output logic [127:0]                  o_plain_text,
    output logic [288:0]                  o_bypass_text,
    output logic [$clog2(NUM_REQ)-1:0]    o_src_id,
    output logic [3:0]                    o_inflight,
    output logic                          o_len_err
);

    localparam int          IW   = $clog2(NUM_REQ);
    localparam logic [6:0]  WMAX = 7'(MAX_WORDS);
    localparam logic [3:0]  IMAX = 4'(MAX_INFLIGHT);

    state_t             state_q, state_d;
    logic [IW-1:0]      gnt_q, gnt_d, rr_q, rr_d, rr_next, arb_id;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [6:0]         wcnt_q, wcnt_d;
    logic [3:0]         inflight_q;
    logic               len_err_q, len_err_d;
    logic               acc, start, last_w, done;
    logic               sel_valid, sel_last;
    logic [BLOCK_W-1:0]  sel_text;
    logic [BYPASS_W-1:0] sel_byp;

    aes_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (i_req_valid),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    always_comb begin
        sel_text = '0;
        sel_byp  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q == IW'(k)) begin
                sel_text = i_req_text[k*BLOCK_W +: BLOCK_W];
                sel_byp  = i_req_bypass[k*BYPASS_W +: BYPASS_W];
            end
        end
    end

    assign sel_valid = i_req_valid[gnt_q];
    assign sel_last  = i_req_last[gnt_q];
    assign rr_next   = (gnt_q == IW'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
    assign done      = i_pkt_done && (inflight_q != 4'd0);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        wcnt_d      = wcnt_q;
        len_err_d   = len_err_q;
        o_req_ready = '0;
        acc         = 1'b0;
        start       = 1'b0;
        last_w      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inflight_q < IMAX && |arb_gnt) begin
                    gnt_d   = arb_id;
                    wcnt_d  = 7'd1;
                    state_d = FIRST;
                end
            end
            FIRST, BODY: begin
                o_req_ready[gnt_q] = sel_valid;
                if (sel_valid) begin
                    acc    = 1'b1;
                    start  = (state_q == FIRST);
                    last_w = sel_last || (wcnt_q == WMAX);
                    if (sel_last) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end else if (wcnt_q == WMAX) begin
                        // truncated: swallow the rest of this source's packet
                        state_d   = DRAIN;
                        rr_d      = rr_next;
                        len_err_d = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + 7'd1;
                        state_d = BODY;
                    end
                end
            end
            DRAIN: begin
                o_req_ready[gnt_q] = sel_valid;
                if (sel_valid && sel_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rr_q          <= '0;
            wcnt_q        <= '0;
            len_err_q     <= 1'b0;
            inflight_q    <= '0;
            o_new         <= 1'b0;
            o_last        <= 1'b0;
            o_plain_text  <= '0;
            o_bypass_text <= '0;
            o_src_id      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            wcnt_q    <= wcnt_d;
            len_err_q <= len_err_d;
            if (start && !done)
                inflight_q <= inflight_q + 4'd1;
            else if (done && !start)
                inflight_q <= inflight_q - 4'd1;
            o_new  <= acc;
            o_last <= acc && last_w;
            if (acc) begin
                o_plain_text  <= sel_text;
                o_bypass_text <= sel_byp;
                o_src_id      <= gnt_q;
            end
        end
    end

    assign o_inflight = inflight_q;
    assign o_len_err  = len_err_q;

endmodule
